// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, the block FIFO entry type and the pad helper for the
// aes_engine block feeder.
//   BLOK_W        width of one AES block
//   BAYT_W        width of one input byte
//   BAYT_SAYISI   bytes per block
//   BAYT_SAYAC_W  width of the byte-position counter
package aes_pkg;

  localparam int BLOK_W       = 128;
  localparam int BAYT_W       = 8;
  localparam int BAYT_SAYISI  = 16;
  localparam int BAYT_SAYAC_W = 4;

  // One queued block: last-of-message flag, real byte count (1..16), data.
  typedef struct packed {
    logic                    son;
    logic [BAYT_SAYAC_W:0]   bayt;
    logic [BLOK_W-1:0]       blok;
  } blok_girdi_t;

  // Lanes below k come from the assembly register, lane k takes the incoming
  // byte, lanes above k take the pad byte. Lane 0 sits at [127:120].
  function automatic logic [BLOK_W-1:0] blok_doldur(
    input logic [BLOK_W-1:0]       asm_blok,
    input logic [BAYT_SAYAC_W-1:0] k,
    input logic [BAYT_W-1:0]       yeni,
    input logic [BAYT_W-1:0]       pad
  );
    logic [BLOK_W-1:0] sonuc;
    sonuc = '0;
    for (int i = 0; i < BAYT_SAYISI; i++) begin
      if (i < int'(k)) begin
        sonuc[BLOK_W-1-BAYT_W*i -: BAYT_W] = asm_blok[BLOK_W-1-BAYT_W*i -: BAYT_W];
      end else if (i == int'(k)) begin
        sonuc[BLOK_W-1-BAYT_W*i -: BAYT_W] = yeni;
      end else begin
        sonuc[BLOK_W-1-BAYT_W*i -: BAYT_W] = pad;
      end
    end
    return sonuc;
  endfunction

endpackage

// File: rtl/aes_blok_fifo.sv
// aes_blok_fifo: synchronous DEPTH-entry FIFO of finished blocks.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_push, i_veri write one entry (ignored when full)
//   i_pop          drop the head entry (ignored when empty)
//   o_veri         head entry, read straight from the storage array
//   o_dolu, o_bos  full / empty flags
module aes_blok_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  blok_girdi_t i_veri,
  input  logic        i_pop,
  output blok_girdi_t o_veri,
  output logic        o_dolu,
  output logic        o_bos
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DOLU = (AW+1)'(DEPTH);

  blok_girdi_t r_mem [DEPTH];
  logic [AW-1:0] r_yaz_ptr;
  logic [AW-1:0] r_oku_ptr;
  logic [AW:0]   r_sayac;

  logic w_yaz;
  logic w_oku;

  assign o_dolu = (r_sayac == C_DOLU);
  assign o_bos  = (r_sayac == '0);
  assign w_yaz  = i_push & ~o_dolu;
  assign w_oku  = i_pop & ~o_bos;
  assign o_veri = r_mem[r_oku_ptr];

  // Storage is cleared on reset so the head reads as zero afterwards.
  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_yaz_ptr <= '0;
      r_oku_ptr <= '0;
      r_sayac   <= '0;
    end else begin
      if (w_yaz) begin
        r_mem[r_yaz_ptr] <= i_veri;
        r_yaz_ptr        <= r_yaz_ptr + 1'b1;
      end
      if (w_oku) r_oku_ptr <= r_oku_ptr + 1'b1;
      if (w_yaz && !w_oku)      r_sayac <= r_sayac + 1'b1;
      else if (!w_yaz && w_oku) r_sayac <= r_sayac - 1'b1;
    end
  end

endmodule

// File: rtl/aes_blok_toplayici.sv
// aes_blok_toplayici: packs a byte stream into 128-bit blocks for aes_engine.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_veri           input byte; i_veri_gecerli its valid; i_veri_son last byte
//   o_veri_hazir     a byte can be accepted this cycle
//   o_blok           head block, first byte at [127:120]
//   o_blok_bayt      real bytes in o_blok (1..16); o_blok_son last block flag
//   o_g_gecerli      o_blok valid; i_hazir aes_engine accepts a block
// Handshakes: a transfer happens on any rising edge where valid and ready are
// both high; valid, once raised, holds with its payload stable until that edge.
// Neither ready output depends combinationally on the matching valid input.
module aes_blok_toplayici
  import aes_pkg::*;
#(
  parameter int                 DEPTH    = 2,
  parameter logic [BAYT_W-1:0]  PAD_BYTE = 8'h00
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [BAYT_W-1:0]       i_veri,
  input  logic                    i_veri_gecerli,
  input  logic                    i_veri_son,
  output logic                    o_veri_hazir,
  output logic [BLOK_W-1:0]       o_blok,
  output logic [BAYT_SAYAC_W:0]   o_blok_bayt,
  output logic                    o_blok_son,
  output logic                    o_g_gecerli,
  input  logic                    i_hazir
);

  logic [BAYT_SAYAC_W-1:0] r_k;
  logic [BLOK_W-1:0]       r_asm;

  logic              w_dolu;
  logic              w_bos;
  logic              w_kabul;
  logic              w_push;
  logic              w_pop;
  logic [BLOK_W-1:0] w_doldur;
  blok_girdi_t       w_girdi;
  blok_girdi_t       w_bas;

  // Held low while reset is asserted so no byte is taken during reset.
  assign o_veri_hazir = ~w_dolu & ~i_rst;
  assign w_kabul      = i_veri_gecerli & o_veri_hazir;
  // The completing byte goes straight into the FIFO in its own cycle.
  assign w_push       = w_kabul & ((r_k == 4'hF) | i_veri_son);
  assign w_pop        = ~w_bos & i_hazir;
  assign w_doldur     = blok_doldur(r_asm, r_k, i_veri, PAD_BYTE);

  assign w_girdi.son  = i_veri_son;
  assign w_girdi.bayt = {1'b0, r_k} + 5'd1;
  assign w_girdi.blok = w_doldur;

  assign o_g_gecerli  = ~w_bos;
  assign o_blok       = w_bas.blok;
  assign o_blok_bayt  = w_bas.bayt;
  assign o_blok_son   = w_bas.son;

  // Lanes above k in r_asm may hold stale or pad bytes; they are never
  // used because every new block starts with k at 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k   <= '0;
      r_asm <= '0;
    end else if (w_kabul) begin
      r_asm <= w_doldur;
      r_k   <= w_push ? '0 : r_k + 1'b1;
    end
  end

  aes_blok_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (w_push),
    .i_veri (w_girdi),
    .i_pop  (w_pop),
    .o_veri (w_bas),
    .o_dolu (w_dolu),
    .o_bos  (w_bos)
  );

endmodule
